// File: rtl/fib_job_scheduler.sv
// Round-robin front end that shares one sequential BCD Fibonacci engine between two requesters.
// It validates operands, supervises the engine with a timeout and returns a tagged valid/ready response.
module fib_job_scheduler #(
    parameter int unsigned ITER_W         = 8,
    parameter int unsigned RESULT_W       = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                req0_valid_i,
    input  logic [ITER_W-1:0]   req0_iter_bcd_i,
    output logic                req0_ready_o,
    input  logic                req1_valid_i,
    input  logic [ITER_W-1:0]   req1_iter_bcd_i,
    output logic                req1_ready_o,
    input  logic                eng_busy_i,
    output logic                eng_start_o,
    output logic [ITER_W-1:0]   eng_iter_bcd_o,
    input  logic                eng_done_i,
    input  logic [RESULT_W-1:0] eng_result_bcd_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic                rsp_id_o,
    output logic [RESULT_W-1:0] rsp_result_bcd_o,
    output logic                rsp_err_o,
    output logic                rsp_timeout_o,
    output logic                busy_o
);
    localparam int unsigned      TMR_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_e;

    state_e              state_q, state_d;
    logic                last_id_q, last_id_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [ITER_W-1:0]   oper_q, oper_d;
    logic                id_q, id_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic                err_q, err_d;
    logic                to_q, to_d;

    logic                grant0, grant1, accept;
    logic [ITER_W-1:0]   sel_iter;

    function automatic logic bcd_ok(input logic [ITER_W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < ITER_W / 4; i++) begin
            if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // When both requesters are valid, the one not served last wins.
    always_comb begin
        grant1 = req1_valid_i & (~req0_valid_i | ~last_id_q);
        grant0 = req0_valid_i & ~grant1;
    end

    assign req0_ready_o = reset_ni & (state_q == IDLE) & grant0;
    assign req1_ready_o = reset_ni & (state_q == IDLE) & grant1;
    assign accept       = req0_ready_o | req1_ready_o;
    assign sel_iter     = grant1 ? req1_iter_bcd_i : req0_iter_bcd_i;

    always_comb begin
        state_d        = state_q;
        last_id_d      = last_id_q;
        timer_d        = timer_q;
        oper_d         = oper_q;
        id_d           = id_q;
        result_d       = result_q;
        err_d          = err_q;
        to_d           = to_q;
        eng_start_o    = 1'b0;
        eng_iter_bcd_o = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    oper_d    = sel_iter;
                    id_d      = grant1;
                    last_id_d = grant1;
                    err_d     = 1'b0;
                    to_d      = 1'b0;
                    if (bcd_ok(sel_iter)) begin
                        state_d = ISSUE;
                    end else begin
                        err_d    = 1'b1;
                        result_d = '0;
                        state_d  = RESPOND;
                    end
                end
            end
            ISSUE: begin
                if (!eng_busy_i) begin
                    eng_start_o    = 1'b1;
                    eng_iter_bcd_o = oper_q;
                    timer_d        = '0;
                    state_d        = WAIT;
                end
            end
            WAIT: begin
                timer_d = timer_q + 1'b1;
                if (eng_done_i) begin
                    result_d = eng_result_bcd_i;
                    state_d  = RESPOND;
                end else if (timer_q == TMR_LAST) begin
                    result_d = '0;
                    to_d     = 1'b1;
                    state_d  = RESPOND;
                end
            end
            RESPOND: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            last_id_q <= 1'b1;
            timer_q   <= '0;
            oper_q    <= '0;
            id_q      <= 1'b0;
            result_q  <= '0;
            err_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_id_q <= last_id_d;
            timer_q   <= timer_d;
            oper_q    <= oper_d;
            id_q      <= id_d;
            result_q  <= result_d;
            err_q     <= err_d;
            to_q      <= to_d;
        end
    end

    assign rsp_valid_o      = (state_q == RESPOND);
    assign busy_o           = (state_q != IDLE);
    assign rsp_id_o         = id_q;
    assign rsp_result_bcd_o = result_q;
    assign rsp_err_o        = err_q;
    assign rsp_timeout_o    = to_q;

endmodule

// File: tb/tb_fib_job_scheduler.sv
// Directed and randomized jobs against a behavioural engine model and a latency/arbitration reference.
module tb_fib_job_scheduler;
    localparam int unsigned ITER_W = 8;
    localparam int unsigned RESULT_W = 16;
    localparam int TO = 32;

    logic clk = 1'b0;
    logic reset_n;
    logic req0_valid, req1_valid, req0_ready_o, req1_ready_o;
    logic [ITER_W-1:0] req0_iter, req1_iter, eng_iter_bcd_o;
    logic eng_busy, eng_start_o, eng_done;
    logic [RESULT_W-1:0] eng_result, rsp_result_bcd_o;
    logic rsp_valid_o, rsp_ready, rsp_id_o, rsp_err_o, rsp_timeout_o, busy_o;

    fib_job_scheduler #(.ITER_W(ITER_W), .RESULT_W(RESULT_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .reset_ni(reset_n),
        .req0_valid_i(req0_valid), .req0_iter_bcd_i(req0_iter), .req0_ready_o(req0_ready_o),
        .req1_valid_i(req1_valid), .req1_iter_bcd_i(req1_iter), .req1_ready_o(req1_ready_o),
        .eng_busy_i(eng_busy), .eng_start_o(eng_start_o), .eng_iter_bcd_o(eng_iter_bcd_o),
        .eng_done_i(eng_done), .eng_result_bcd_i(eng_result),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id_o),
        .rsp_result_bcd_o(rsp_result_bcd_o), .rsp_err_o(rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < 4; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] ref_fib(input logic [7:0] bcd);
        int n, a, b, t;
        n = int'(bcd[7:4]) * 10 + int'(bcd[3:0]);
        a = 0;
        b = 1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return to_bcd(a);
    endfunction

    function automatic bit bcd_digits_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Engine model: done is high exactly eng_lat cycles after the start cycle (never when eng_lat<0).
    int eng_lat = -1;
    int start_cnt = 0;
    int iter_leak = 0;
    int cnt = -1;
    logic [7:0] start_op = '0;
    logic [15:0] fib_res = '0;

    initial begin
        eng_done = 1'b0;
        eng_result = '0;
        forever begin
            @(negedge clk);
            #2;
            eng_done = 1'b0;
            eng_result = 16'($urandom);
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    eng_done = 1'b1;
                    eng_result = fib_res;
                    cnt = -1;
                end
            end
            if (eng_start_o === 1'b1) begin
                start_cnt++;
                start_op = eng_iter_bcd_o;
                fib_res = ref_fib(eng_iter_bcd_o);
                cnt = eng_lat;
            end else if (eng_iter_bcd_o !== '0) begin
                iter_leak++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic run_job(input int who, input logic [7:0] iter, input int lat,
                           input int busy_n, input int hold, input string tag);
        int s0, k, start_at, exp_lat, unstable, leak;
        bit bad, exp_to, seen;
        logic [15:0] exp_res;
        logic [15:0] r0;
        logic id0;
        bad = !bcd_digits_ok(iter);
        exp_to = !bad && (lat < 0 || lat > TO);
        exp_res = (bad || exp_to) ? 16'h0 : ref_fib(iter);
        exp_lat = bad ? 1 : busy_n + 2 + (exp_to ? TO : lat);
        eng_lat = lat;
        s0 = start_cnt;
        @(negedge clk);
        eng_busy = (busy_n > 0);
        if (who == 0) begin
            req0_valid = 1'b1; req0_iter = iter;
        end else begin
            req1_valid = 1'b1; req1_iter = iter;
        end
        #1;
        check({tag, " accept"}, (who == 0) ? {req1_ready_o, req0_ready_o} : {req0_ready_o, req1_ready_o}, 2'b01);
        k = 0;
        seen = 1'b0;
        start_at = -1;
        while (!seen && k < 400) begin
            @(negedge clk);
            k++;
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            eng_busy = (k <= busy_n);
            #1;
            if (eng_start_o && start_at < 0) start_at = k;
            seen = rsp_valid_o;
        end
        check({tag, " latency"}, k, exp_lat);
        check({tag, " starts"}, start_cnt - s0, bad ? 0 : 1);
        if (!bad) begin
            check({tag, " start cycle"}, start_at, busy_n + 1);
            check({tag, " start operand"}, start_op, iter);
        end
        check({tag, " rsp fields"}, {rsp_id_o, rsp_err_o, rsp_timeout_o, rsp_result_bcd_o},
              {1'(who), bad, exp_to, exp_res});
        id0 = rsp_id_o;
        r0 = rsp_result_bcd_o;
        unstable = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            req0_valid = 1'b1; req0_iter = 8'h01;
            req1_valid = 1'b1; req1_iter = 8'h02;
            #1;
            if (!rsp_valid_o || rsp_id_o !== id0 || rsp_result_bcd_o !== r0 ||
                req0_ready_o || req1_ready_o) unstable++;
        end
        check({tag, " held"}, unstable, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check({tag, " valid at handshake"}, rsp_valid_o, 1'b1);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check({tag, " idle after"}, {rsp_valid_o, busy_o}, 2'b00);
        leak = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (rsp_valid_o || busy_o) leak++;
        end
        check({tag, " quiet drain"}, leak, 0);
    endtask

    task automatic contention(input int njobs, input string tag);
        int acc[$];
        int rid[$];
        logic [15:0] rres[$];
        int both, last_m, e, g;
        both = 0;
        last_m = 1;
        @(negedge clk);
        eng_lat = 3;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_iter = 8'h05;
        req1_valid = 1'b1; req1_iter = 8'h07;
        #1;
        for (int c = 0; c < 400 && rid.size() < njobs; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            if (req0_ready_o && req1_ready_o) both++;
            if (req0_ready_o) acc.push_back(0);
            else if (req1_ready_o) acc.push_back(1);
            if (rsp_valid_o) begin
                rid.push_back(int'(rsp_id_o));
                rres.push_back(rsp_result_bcd_o);
            end
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        check({tag, " responses"}, rid.size(), njobs);
        for (int j = 0; j < njobs; j++) begin
            e = 1 - last_m;
            last_m = e;
            g = (j < acc.size()) ? acc[j] : -1;
            check({tag, " grant"}, g, e);
            check({tag, " id"}, (j < rid.size()) ? rid[j] : -1, e);
            check({tag, " result"}, (j < rres.size()) ? rres[j] : 16'hdead,
                  ref_fib(e ? 8'h07 : 8'h05));
        end
        check({tag, " both ready"}, both, 0);
        repeat (6) @(negedge clk);
    endtask

    function automatic logic [31:0] all_outs();
        return {req0_ready_o, req1_ready_o, eng_start_o, eng_iter_bcd_o, rsp_valid_o, rsp_id_o,
                rsp_result_bcd_o, rsp_err_o, rsp_timeout_o, busy_o};
    endfunction

    initial begin
        int who, lat, busy_n, hold, n;
        logic [7:0] it;
        reset_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_iter = '0; req1_iter = '0;
        eng_busy = 1'b0;
        rsp_ready = 1'b0;
        #12;
        check("reset outputs", all_outs(), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        contention(4, "contend4");
        run_job(0, 8'h10, 30, 0, 0, "single");
        run_job(1, 8'h1A, 5, 0, 0, "bad bcd");
        run_job(0, 8'h07, 5, 10, 0, "busy eng");
        run_job(1, 8'h09, TO, 0, 0, "done at limit");
        run_job(0, 8'h12, TO + 3, 0, 0, "timeout");
        run_job(1, 8'h12, 4, 0, 0, "after timeout");
        run_job(0, 8'h15, 6, 0, 20, "backpressure");
        check("iter zero when idle", iter_leak, 0);

        for (int j = 0; j < 20; j++) begin
            who = int'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                it = 8'($urandom);
            end else begin
                n = int'($urandom_range(0, 20));
                it = {4'(n / 10), 4'(n % 10)};
            end
            lat = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, TO + 3));
            busy_n = int'($urandom_range(0, 3));
            hold = int'($urandom_range(0, 3));
            run_job(who, it, lat, busy_n, hold, "random");
        end

        // Abandon a req0 job mid-WAIT; afterwards req0 must still be favoured.
        eng_lat = -1;
        @(negedge clk);
        req0_valid = 1'b1; req0_iter = 8'h08;
        repeat (5) @(negedge clk);
        req0_valid = 1'b0;
        #1;
        check("pre-reset busy", busy_o, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid-job reset outputs", all_outs(), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        contention(2, "post-reset");
        check("iter zero final", iter_leak, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
